// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Package : mips_mem_pkg
// Purpose : Shared constants and FSM encoding for the MEM-stage SRAM
//           controller. Defaults are also used by the SRAM model in the bench.
// Contents: SRAM_AW_DEF, SRAM_DW, ADDR_BASE_DEF, WAIT_CYCLES_DEF, state_t and
//           the ST_* state constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  // SRAM geometry: half-word addressed, 16-bit data bus.
  localparam int unsigned SRAM_AW_DEF     = 18;
  localparam int unsigned SRAM_DW         = 16;

  // CPU byte address that maps to SRAM word 0.
  localparam int unsigned ADDR_BASE_DEF   = 1024;

  // Extra cycles each half-access is held; legal range 0..7 (3-bit counter).
  localparam int unsigned WAIT_CYCLES_DEF = 1;

  // Controller FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sram_half_access.sv
// ============================================================================
// Module  : sram_half_access
// Purpose : Executes one 16-bit access on an asynchronous SRAM. A start pulse
//           loads address, data and direction; the access then lasts
//           WAIT_CYCLES+1 cycles. For writes, we_n is low in every cycle
//           except the last, so address and data are held across the we_n
//           rising edge. All SRAM-facing signals are registered.
// Ports   : clk, rst        clock / async active-high reset
//           start_i         begin a new half access next cycle
//           write_i         1 = write, 0 = read (sampled with start_i)
//           addr_i, wdata_i half-word address and write data
//           last_o          current cycle is the last one of this half
//           sram_addr_o     registered SRAM address
//           sram_we_n_o     registered SRAM write strobe (active low)
//           sram_dq_io      SRAM data bus, driven only during writes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_half_access #(
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               write_i,
  input  logic [SRAM_AW-1:0] addr_i,
  input  logic [15:0]        wdata_i,
  output logic               last_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               sram_we_n_o,
  inout  wire  [15:0]        sram_dq_io
);

  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

  logic               active_q, active_d;
  logic               write_q,  write_d;
  logic [2:0]         wcnt_q,   wcnt_d;
  logic               we_n_q,   we_n_d;
  logic               oe_q,     oe_d;
  logic [15:0]        dout_q,   dout_d;
  logic [SRAM_AW-1:0] addr_q,   addr_d;
  logic [2:0]         wcnt_inc;

  assign wcnt_inc = wcnt_q + 3'd1;
  assign last_o   = active_q && (wcnt_q == WAIT_C);

  always_comb begin
    active_d = active_q;
    write_d  = write_q;
    wcnt_d   = wcnt_q;
    we_n_d   = we_n_q;
    oe_d     = oe_q;
    dout_d   = dout_q;
    addr_d   = addr_q;
    if (start_i) begin
      // First cycle of a write is never the hold cycle unless WAIT_CYCLES=0,
      // in which case the single cycle is the strobe cycle.
      active_d = 1'b1;
      write_d  = write_i;
      wcnt_d   = 3'd0;
      addr_d   = addr_i;
      dout_d   = wdata_i;
      oe_d     = write_i;
      we_n_d   = ~write_i;
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
        wcnt_d   = 3'd0;
        we_n_d   = 1'b1;
        oe_d     = 1'b0;
      end else begin
        wcnt_d = wcnt_inc;
        // Raise we_n one cycle early so the next (last) cycle is the hold.
        we_n_d = ~(write_q && (wcnt_inc != WAIT_C));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      write_q  <= 1'b0;
      wcnt_q   <= 3'd0;
      we_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= 16'h0000;
      addr_q   <= '0;
    end else begin
      active_q <= active_d;
      write_q  <= write_d;
      wcnt_q   <= wcnt_d;
      we_n_q   <= we_n_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      addr_q   <= addr_d;
    end
  end

  assign sram_addr_o = addr_q;
  assign sram_we_n_o = we_n_q;
  assign sram_dq_io  = oe_q ? dout_q : 16'bz;

endmodule

`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
// ============================================================================
// Module  : mem_stage_sram_ctrl
// Purpose : MEM-stage data-memory controller. Turns each 32-bit load/store
//           from the EXE->MEM register into two 16-bit SRAM accesses (low
//           half, then high half) and holds ready low until the word is done.
// Ports   : clk, rst        clock / async active-high reset
//           mem_r_en_i      load request
//           mem_w_en_i      store request (wins over load)
//           alu_result_i    byte address (low two bits ignored)
//           st_val_i        store data
//           rd_data_o       load result, held until the next load completes
//           ready_o         0 = freeze the pipeline
//           sram_addr_o     SRAM half-word address
//           sram_dq_io      SRAM data bus
//           sram_we_n_o     SRAM write strobe, active low
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_sram_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en_i,
  input  logic               mem_w_en_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        st_val_i,
  output logic [31:0]        rd_data_o,
  output logic               ready_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  inout  wire  [15:0]        sram_dq_io,
  output logic               sram_we_n_o
);

  state_t             state_q,   state_d;
  logic               write_q,   write_d;
  logic [SRAM_AW-2:0] word_q,    word_d;
  logic [31:0]        st_val_q,  st_val_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic               w_req;
  logic [31:0]        w_offset;
  logic [SRAM_AW-2:0] w_word;
  logic               w_unused_bits;

  logic               ha_start;
  logic               ha_write;
  logic [SRAM_AW-1:0] ha_addr;
  logic [15:0]        ha_wdata;
  logic               ha_last;

  assign w_req = mem_r_en_i | mem_w_en_i;

  // Word index modulo the SRAM size: anything outside simply wraps.
  assign w_offset      = alu_result_i - 32'(ADDR_BASE);
  assign w_word        = w_offset[SRAM_AW:2];
  assign w_unused_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    word_d    = word_q;
    st_val_d  = st_val_q;
    rd_data_d = rd_data_q;
    ha_start  = 1'b0;
    ha_write  = write_q;
    ha_addr   = {word_q, 1'b0};
    ha_wdata  = st_val_q[15:0];
    ready_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stall in the request cycle itself so the pipeline freezes at once.
        ready_o = ~w_req;
        if (w_req) begin
          state_d  = ST_LO;
          write_d  = mem_w_en_i;
          word_d   = w_word;
          st_val_d = st_val_i;
          ha_start = 1'b1;
          ha_write = mem_w_en_i;
          ha_addr  = {w_word, 1'b0};
          ha_wdata = st_val_i[15:0];
        end
      end
      ST_LO: begin
        if (ha_last) begin
          state_d = ST_HI;
          if (!write_q) rd_data_d[15:0] = sram_dq_io;
          ha_start = 1'b1;
          ha_addr  = {word_q, 1'b1};
          ha_wdata = st_val_q[31:16];
        end
      end
      ST_HI: begin
        if (ha_last) begin
          state_d = ST_DONE;
          if (!write_q) rd_data_d[31:16] = sram_dq_io;
        end
      end
      ST_DONE: begin
        ready_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      word_q    <= '0;
      st_val_q  <= 32'h0;
      rd_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      word_q    <= word_d;
      st_val_q  <= st_val_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

  sram_half_access #(
    .SRAM_AW     (SRAM_AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_half (
    .clk         (clk),
    .rst         (rst),
    .start_i     (ha_start),
    .write_i     (ha_write),
    .addr_i      (ha_addr),
    .wdata_i     (ha_wdata),
    .last_o      (ha_last),
    .sram_addr_o (sram_addr_o),
    .sram_we_n_o (sram_we_n_o),
    .sram_dq_io  (sram_dq_io)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
// ============================================================================
// Module  : tb_mem_stage_sram_ctrl
// Purpose : Self-checking bench for mem_stage_sram_ctrl. Two instances share
//           the clock: u_dut1 (WAIT_CYCLES=1) and u_dut0 (WAIT_CYCLES=0), each
//           attached to its own behavioural 16-bit SRAM. Expected load data
//           comes from a word-level memory model keyed by word index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_sram_ctrl;
  import mips_mem_pkg::*;

  localparam int          AW     = SRAM_AW_DEF;
  localparam int unsigned BASE   = ADDR_BASE_DEF;
  localparam int unsigned NWORDS = 1 << (AW - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_CYCLES=1 instance
  logic          r1, w1, rdy1, we1, oe1;
  logic [31:0]   a1, d1, rd1;
  logic [AW-1:0] addr1;
  wire  [15:0]   dq1;
  // WAIT_CYCLES=0 instance
  logic          r0, w0, rdy0, we0, oe0;
  logic [31:0]   a0, d0, rd0;
  logic [AW-1:0] addr0;
  wire  [15:0]   dq0;

  mem_stage_sram_ctrl #(.SRAM_AW(AW), .ADDR_BASE(BASE), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en_i(r1), .mem_w_en_i(w1), .alu_result_i(a1),
    .st_val_i(d1), .rd_data_o(rd1), .ready_o(rdy1), .sram_addr_o(addr1),
    .sram_dq_io(dq1), .sram_we_n_o(we1));

  mem_stage_sram_ctrl #(.SRAM_AW(AW), .ADDR_BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en_i(r0), .mem_w_en_i(w0), .alu_result_i(a0),
    .st_val_i(d0), .rd_data_o(rd0), .ready_o(rdy0), .sram_addr_o(addr0),
    .sram_dq_io(dq0), .sram_we_n_o(we0));

  // Behavioural async SRAMs: write while we_n is low, drive the bus on loads.
  bit [15:0] sram1 [0:(1<<AW)-1];
  bit [15:0] sram0 [0:(1<<AW)-1];
  assign dq1 = oe1 ? sram1[addr1] : 16'bz;
  assign dq0 = oe0 ? sram0[addr0] : 16'bz;
  always @(negedge clk) if (!we1) sram1[addr1] <= dq1;
  always @(negedge clk) if (!we0) sram0[addr0] <= dq0;

  // Word-level reference memories and expected load registers.
  bit [31:0] ref1 [int unsigned];
  bit [31:0] ref0 [int unsigned];
  logic [31:0] exp_rd1, exp_rd0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] diff;
    diff = a - BASE;
    return int'(diff >> 2) % NWORDS;
  endfunction

  // One full transaction, entered just after a negedge; returns just after
  // the negedge following DONE, so a further call is back-to-back.
  task automatic access(input bit sel0, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    int  wt, stalls, we_lows, exp_we;
    bit  done;
    logic rdy, wen;
    logic [31:0] rd;
    wt = sel0 ? 0 : 1;
    if (sel0) begin r0 = r; w0 = w; a0 = a; d0 = d; oe0 = r & ~w; end
    else      begin r1 = r; w1 = w; a1 = a; d1 = d; oe1 = r & ~w; end
    stalls = 0; we_lows = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      rdy = sel0 ? rdy0 : rdy1;
      wen = sel0 ? we0  : we1;
      if (rdy) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (!wen) we_lows++;
      @(negedge clk);
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq(sel0 ? "stall_w0" : "stall_w1", stalls, 2 * (wt + 1) + 1);
    exp_we = w ? 2 * ((wt > 0) ? wt : 1) : 0;
    check_eq(w ? "we_low_store" : "we_low_load", we_lows, exp_we);
    idx = word_of(a);
    if (sel0) begin
      if (w) ref0[idx] = d;
      else   exp_rd0 = ref0.exists(idx) ? ref0[idx] : 32'h0;
      rd = rd0;
      check_eq(w ? "rd_hold_w0" : "load_w0", rd, exp_rd0);
      r0 = 1'b0; w0 = 1'b0; oe0 = 1'b0;
    end else begin
      if (w) ref1[idx] = d;
      else   exp_rd1 = ref1.exists(idx) ? ref1[idx] : 32'h0;
      rd = rd1;
      check_eq(w ? "rd_hold_w1" : "load_w1", rd, exp_rd1);
      r1 = 1'b0; w1 = 1'b0; oe1 = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) < 8)
      return BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
    else if ($urandom_range(0, 1) == 0)
      return BASE - 4 * $urandom_range(1, 4);
    else
      return BASE + 4 * NWORDS + 4 * $urandom_range(0, 31);
  endfunction

  task automatic rand_traffic(input bit sel0, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      access(sel0, op != 2, op >= 2, rand_addr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned idx;
    logic [31:0] v;
    rst = 1'b1;
    r1 = 0; w1 = 0; a1 = 0; d1 = 0; oe1 = 0;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; oe0 = 0;
    exp_rd1 = 32'h0; exp_rd0 = 32'h0;
    #1;
    check_eq("rst_ready", 32'(rdy1), 32'd1);
    check_eq("rst_we_n", 32'(we1), 32'd1);
    check_eq("rst_rd", rd1, 32'h0);
    check_eq("rst_addr", 32'(addr1), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Store then load of the same word.
    access(1'b0, 1'b0, 1'b1, BASE + 8, 32'hDEADBEEF);
    check_eq("sram4", 32'(sram1[4]), 32'h0000BEEF);
    check_eq("sram5", 32'(sram1[5]), 32'h0000DEAD);
    access(1'b0, 1'b1, 1'b0, BASE + 8, 32'h0);

    // Back-to-back store and load: the load's stall count proves no bubble.
    v = $urandom;
    access(1'b0, 1'b0, 1'b1, BASE + 0, v);
    access(1'b0, 1'b1, 1'b0, BASE + 0, 32'h0);
    check_eq("b2b_value", rd1, v);

    // Both enables: store wins, rd_data untouched; then read it back.
    access(1'b0, 1'b1, 1'b1, BASE + 12, 32'h12345678);
    access(1'b0, 1'b1, 1'b0, BASE + 12, 32'h0);

    // Reset in the middle of a store's high half.
    a1 = BASE + 64; d1 = 32'hCAFEF00D; w1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_we_low", 32'(we1), 32'd0);
    #1;
    rst = 1'b1; w1 = 1'b0;
    #1;
    check_eq("arst_we_n", 32'(we1), 32'd1);
    check_eq("arst_ready", 32'(rdy1), 32'd1);
    check_eq("arst_rd", rd1, 32'h0);
    idx = word_of(BASE + 64);
    check_eq("arst_lo_half", 32'(sram1[2 * idx]), 32'h0000F00D);
    ref1[idx] = {sram1[2 * idx + 1], sram1[2 * idx]};
    exp_rd1 = 32'h0; exp_rd0 = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b1, 1'b0, BASE + 64, 32'h0);

    rand_traffic(1'b0, 60);

    // WAIT_CYCLES=0 instance: wrap below base to the top SRAM word.
    access(1'b1, 1'b0, 1'b1, BASE - 4, 32'hA5A55A5A);
    check_eq("wrap_lo", 32'(sram0[(1 << AW) - 2]), 32'h00005A5A);
    check_eq("wrap_hi", 32'(sram0[(1 << AW) - 1]), 32'h0000A5A5);
    access(1'b1, 1'b1, 1'b0, BASE - 4, 32'h0);
    access(1'b1, 1'b1, 1'b0, BASE + 4 * NWORDS - 4, 32'h0);
    check_eq("wrap_alias", rd0, 32'hA5A55A5A);
    rand_traffic(1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
